// File: rtl/aes_128_enc_pkg.sv
// Shared AES-128 definitions: state layout, round constants, S-box,
// GF(2^8) helpers and one step of the on-the-fly key expansion.
package aes_pkg;

  // Column-major 4x4 byte state: s[col][row]; s[0][0] sits in bits [127:120]
  typedef logic [0:3][0:3][7:0] state_t;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } fsm_t;

  localparam int unsigned NK = 4;
  localparam logic [3:0] NR = 4'd10;

  // Rcon[r] indexed by round number; unused slots are zero
  localparam logic [0:15][7:0] RCON_TABLE = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  // Forward S-box as a full 256-entry lookup
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] s;
    s = 8'h00;
    case (b)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  // Multiply by x in GF(2^8), reducing with x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  // Derive the next round key from the current one and its round constant
  function automatic state_t key_step(input state_t rk, input logic [7:0] rc);
    logic [31:0] w3;
    logic [31:0] t;
    state_t      n;
    w3   = rk[3];
    t    = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    n[0] = rk[0] ^ t;
    n[1] = rk[1] ^ n[0];
    n[2] = rk[2] ^ n[1];
    n[3] = rk[3] ^ n[2];
    return n;
  endfunction

endpackage

// File: rtl/aes_128_enc_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows,
// MixColumns (skipped on the last round) and AddRoundKey.
module aes_round
  import aes_pkg::*;
(
  input  state_t state,
  input  state_t round_key,
  input  logic   final_round,
  output state_t next_state
);

  state_t sub;
  state_t shf;
  state_t mix;

  // Byte substitution followed by the row rotation (row r moves left by r)
  always_comb begin
    sub = '0;
    shf = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sub[c][r] = sbox(state[c][r]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shf[c][r] = sub[(c + r) & 3][r];
      end
    end
  end

  // Column mixing, bypassed on the final round, then the round key is added
  always_comb begin
    mix = '0;
    for (int c = 0; c < 4; c++) begin
      mix[c][0] = gf_mul2(shf[c][0]) ^ gf_mul3(shf[c][1]) ^ shf[c][2] ^ shf[c][3];
      mix[c][1] = shf[c][0] ^ gf_mul2(shf[c][1]) ^ gf_mul3(shf[c][2]) ^ shf[c][3];
      mix[c][2] = shf[c][0] ^ shf[c][1] ^ gf_mul2(shf[c][2]) ^ gf_mul3(shf[c][3]);
      mix[c][3] = gf_mul3(shf[c][0]) ^ shf[c][1] ^ shf[c][2] ^ gf_mul2(shf[c][3]);
    end
    next_state = (final_round ? shf : mix) ^ round_key;
  end

endmodule

// File: rtl/aes_128_enc.sv
// Iterative AES-128 encryption core: one round per clock with the round
// keys expanded alongside the datapath, behind a valid/ready request port.
module aes_128_enc
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_bus,
  input  logic [127:0] key,
  output logic         out_valid,
  output logic [127:0] out_bus
);

  fsm_t       fsm;
  logic [3:0] round_cnt;
  state_t     state_q;
  state_t     rk_q;
  state_t     next_rk;
  state_t     round_out;
  logic       last_round;

  assign in_ready   = (fsm == ST_IDLE);
  assign last_round = (round_cnt == NR);
  assign next_rk    = key_step(rk_q, RCON_TABLE[round_cnt]);

  aes_round u_round (
    .state       (state_q),
    .round_key   (next_rk),
    .final_round (last_round),
    .next_state  (round_out)
  );

  // Handshake, round sequencing and result register in one state machine
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= ST_IDLE;
      round_cnt <= '0;
      state_q   <= '0;
      rk_q      <= '0;
      out_valid <= 1'b0;
      out_bus   <= '0;
    end else begin
      out_valid <= 1'b0;
      case (fsm)
        ST_IDLE: begin
          if (in_valid) begin
            state_q   <= in_bus ^ key;
            rk_q      <= key;
            round_cnt <= 4'd1;
            fsm       <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          state_q <= round_out;
          rk_q    <= next_rk;
          if (last_round) begin
            out_bus   <= round_out;
            out_valid <= 1'b1;
            round_cnt <= '0;
            fsm       <= ST_IDLE;
          end else begin
            round_cnt <= round_cnt + 4'd1;
          end
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_128_enc.sv
// Directed-vector bench for the iterative AES-128 encryption core.
module tb_aes_128_enc;

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] R0_C  = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] R1_C  = 128'h89d810e8855ace682d1843d8cb128fe4;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_bus;
  logic [127:0] key;
  logic         out_valid;
  logic [127:0] out_bus;

  int total = 0;
  int bad   = 0;

  aes_128_enc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bus    (in_bus),
    .key       (key),
    .out_valid (out_valid),
    .out_bus   (out_bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for in_ready, then holds one request across its accept edge
  task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] k);
    int w;
    w = 0;
    while (!in_ready && w < 40) begin
      @(posedge clk);
      #1;
      w++;
    end
    checkOutput("ready_before_req", 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    in_bus   = pt;
    key      = k;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_bus   = ~pt;
    key      = ~k;
  endtask

  // Counts edges from the accept edge (edge 1) until out_valid is seen
  task automatic waitResult(input string tag, input logic [127:0] exp, input int edges_in);
    int e;
    e = edges_in;
    while (!out_valid && e < 40) begin
      @(posedge clk);
      #1;
      e++;
    end
    checkOutput({tag, "_latency"}, 128'(e), 128'd11);
    checkOutput({tag, "_ct"}, out_bus, exp);
  endtask

  initial begin
    int pulses;
    int changes;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_bus   = '0;
    key      = '0;
    #12;
    checkOutput("rst_out_valid", 128'(out_valid), 128'd0);
    checkOutput("rst_out_bus", out_bus, 128'd0);
    checkOutput("rst_in_ready", 128'(in_ready), 128'd1);
    checkOutput("rst_round_cnt", 128'(dut.round_cnt), 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] App. B vector");
    applyStimulus(PT_B, KEY_B);
    checkOutput("b_busy_ready", 128'(in_ready), 128'd0);
    waitResult("b", CT_B, 1);
    @(posedge clk);
    #1;
    checkOutput("b_pulse_width", 128'(out_valid), 128'd0);

    $display("[TB] App. C.1 vector with intermediate states");
    applyStimulus(PT_C, KEY_C);
    checkOutput("c_round0_state", 128'(dut.state_q), R0_C);
    @(posedge clk);
    #1;
    checkOutput("c_round1_state", 128'(dut.state_q), R1_C);
    waitResult("c", CT_C, 2);

    $display("[TB] all-zero vector");
    @(posedge clk);
    #1;
    applyStimulus('0, '0);
    waitResult("zero", CT_Z, 1);

    $display("[TB] requests while busy are ignored");
    @(posedge clk);
    #1;
    applyStimulus(PT_B, KEY_B);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_bus   = PT_C;
      key      = KEY_C;
      if (i == 1) checkOutput("busy_ignore_ready", 128'(in_ready), 128'd0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    waitResult("busy_ignore", CT_B, 4);

    $display("[TB] back-to-back request in the out_valid cycle");
    checkOutput("b2b_ready_in_pulse", 128'(in_ready), 128'd1);
    applyStimulus(PT_C, KEY_C);
    checkOutput("b2b_pulse_ended", 128'(out_valid), 128'd0);
    checkOutput("b2b_out_held", out_bus, CT_B);
    waitResult("b2b", CT_C, 1);

    $display("[TB] reset during round 5");
    @(posedge clk);
    #1;
    applyStimulus(PT_B, KEY_B);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    checkOutput("abort_round_cnt", 128'(dut.round_cnt), 128'd5);
    rst = 1'b1;
    #1;
    checkOutput("abort_out_valid", 128'(out_valid), 128'd0);
    checkOutput("abort_out_bus", out_bus, 128'd0);
    checkOutput("abort_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pulses = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    checkOutput("abort_no_pulse", 128'(pulses), 128'd0);
    checkOutput("abort_ready_after", 128'(in_ready), 128'd1);
    applyStimulus(PT_B, KEY_B);
    waitResult("after_abort", CT_B, 1);

    $display("[TB] idle hold after completion");
    pulses  = 0;
    changes = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
      if (out_bus !== CT_B) changes++;
    end
    checkOutput("hold_no_pulse", 128'(pulses), 128'd0);
    checkOutput("hold_out_stable", 128'(changes), 128'd0);
    checkOutput("hold_in_ready", 128'(in_ready), 128'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
